// File: rtl/arbitro_vc_pkg.sv
// Shared types and constants for the arbitro_vc weighted round-robin VC scheduler.
// Optional stall counter is enabled with the ARB_STALL_CNT_EN macro (see arbitro_vc.sv).
package arbitro_vc_pkg;

    localparam int unsigned DATA_W_DEF = 6;
    localparam int unsigned CREDIT_W   = 4;
    localparam int unsigned STALL_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN_VC0 = 2'b01,
        RUN_VC1 = 2'b10
    } arb_state_e;

    // The destination select is always the MSB of a word.
    function automatic int unsigned dest_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/arbitro_vc.sv
// Weighted round-robin scheduler moving words from VC0/VC1 FIFOs into D0/D1 FIFOs.
// Define ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module arbitro_vc
    import arbitro_vc_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned VC0_WEIGHT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic              vc0_empty,
    output logic              vc0_pop,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              vc1_empty,
    output logic              vc1_pop,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic [DATA_W-1:0] d_data,
    output logic              d0_push,
    output logic              d1_push,
    output logic              grant_vc
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam int unsigned DST = dest_bit(DATA_W);

    arb_state_e           state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [DATA_W-1:0]    d_data_q, d_data_d;
    logic                 d0_push_q, d0_push_d;
    logic                 d1_push_q, d1_push_d;
    logic                 grant_q, grant_d;

    logic                 dst0, dst1;
    logic                 elig0, elig1;
    logic                 pop0, pop1;
    logic                 last_vc0_slot;

    // A VC is eligible only if its head word's destination can accept one more word.
    assign dst0  = vc0_data[DST];
    assign dst1  = vc1_data[DST];
    assign elig0 = active & ~vc0_empty & ~(dst0 ? d1_almost_full : d0_almost_full);
    assign elig1 = active & ~vc1_empty & ~(dst1 ? d1_almost_full : d0_almost_full);

    assign last_vc0_slot = ((credit_q + CREDIT_W'(1)) == CREDIT_W'(VC0_WEIGHT));

    // Next-state, credit and grant decision.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        pop0     = 1'b0;
        pop1     = 1'b0;

        if (!active) begin
            state_d  = IDLE;
            credit_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = RUN_VC0;
                    credit_d = '0;
                end
                RUN_VC0: begin
                    if (elig0) begin
                        pop0 = 1'b1;
                        if (last_vc0_slot) begin
                            state_d  = RUN_VC1;
                            credit_d = '0;
                        end else begin
                            credit_d = credit_q + CREDIT_W'(1);
                        end
                    end else if (elig1) begin
                        pop1 = 1'b1;
                    end
                end
                RUN_VC1: begin
                    if (elig1) begin
                        pop1     = 1'b1;
                        state_d  = RUN_VC0;
                        credit_d = '0;
                    end else if (elig0) begin
                        pop0 = 1'b1;
                        if (VC0_WEIGHT == 1) begin
                            state_d  = RUN_VC1;
                            credit_d = '0;
                        end else begin
                            state_d  = RUN_VC0;
                            credit_d = CREDIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    credit_d = '0;
                end
            endcase
        end
    end

    assign vc0_pop = pop0 & ~reset;
    assign vc1_pop = pop1 & ~reset;

    // Output stage: the popped word lands one cycle later, routed by its MSB.
    always_comb begin
        d_data_d  = d_data_q;
        grant_d   = grant_q;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        if (pop0) begin
            d_data_d  = vc0_data;
            grant_d   = 1'b0;
            d0_push_d = ~dst0;
            d1_push_d = dst0;
        end else if (pop1) begin
            d_data_d  = vc1_data;
            grant_d   = 1'b1;
            d0_push_d = ~dst1;
            d1_push_d = dst1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            credit_q  <= '0;
            d_data_q  <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            d_data_q  <= d_data_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            grant_q   <= grant_d;
        end
    end

    assign d_data   = d_data_q;
    assign d0_push  = d0_push_q;
    assign d1_push  = d1_push_q;
    assign grant_vc = grant_q;

`ifdef ARB_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;
    logic               stall_inc;

    // Cycles where work is waiting but nothing could be forwarded.
    assign stall_inc = (state_q != IDLE) & active & (~vc0_empty | ~vc1_empty) & ~pop0 & ~pop1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_arbitro_vc.sv
// Self-checking bench for arbitro_vc: queue-based FIFO model plus scheduling reference.
module tb_arbitro_vc;

    localparam int DW = 6;
    localparam int W  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          active;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          vc0_empty, vc1_empty;
    logic          vc0_pop, vc1_pop;
    logic          d0_almost_full, d1_almost_full;
    logic [DW-1:0] d_data;
    logic          d0_push, d1_push, grant_vc;
`ifdef ARB_STALL_CNT_EN
    logic [7:0]    stall_cnt;
`endif

    arbitro_vc #(.DATA_W(DW), .VC0_WEIGHT(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .vc0_data       (vc0_data),
        .vc0_empty      (vc0_empty),
        .vc0_pop        (vc0_pop),
        .vc1_data       (vc1_data),
        .vc1_empty      (vc1_empty),
        .vc1_pop        (vc1_pop),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .d_data         (d_data),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .grant_vc       (grant_vc)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    // Reference: 0 = idle, 1 = VC0 has priority, 2 = VC1 has priority.
    int m_state = 0;
    int streak  = 0;
    int exp_data = 0, exp_p0 = 0, exp_p1 = 0, exp_g = 0, exp_stall = 0;
    int obs_pop;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, expv, $time);
        end
    endtask

    task automatic step(input bit rv, input bit av, input bit a0, input bit a1);
        bit            e0, e1;
        int            want;
        int            s;
        logic [DW-1:0] h0, h1;
        @(negedge clk);
        reset          = rv;
        active         = av;
        d0_almost_full = a0;
        d1_almost_full = a1;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = h0;
        vc1_data  = h1;
        #1;
        if (rv) begin
            exp_data = 0; exp_p0 = 0; exp_p1 = 0; exp_g = 0; exp_stall = 0;
        end
        e0 = av && (q0.size() > 0) && !(h0[DW-1] ? a1 : a0);
        e1 = av && (q1.size() > 0) && !(h1[DW-1] ? a1 : a0);
        want = -1;
        if (!rv && av && m_state != 0) begin
            if (m_state == 2) want = e1 ? 1 : (e0 ? 0 : -1);
            else              want = e0 ? 0 : (e1 ? 1 : -1);
        end

        chk("vc0_pop", int'(vc0_pop), int'(want == 0));
        chk("vc1_pop", int'(vc1_pop), int'(want == 1));
        chk("d_data", int'(d_data), exp_data);
        chk("d0_push", int'(d0_push), exp_p0);
        chk("d1_push", int'(d1_push), exp_p1);
        chk("grant_vc", int'(grant_vc), exp_g);
`ifdef ARB_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt), exp_stall);
`endif
        obs_pop = vc0_pop ? 0 : (vc1_pop ? 1 : -1);

        if (!rv && m_state != 0 && av && (q0.size() > 0 || q1.size() > 0) && want < 0 && exp_stall < 255)
            exp_stall++;

        if (want == 0) begin
            exp_data = int'(h0); exp_p0 = h0[DW-1] ? 0 : 1; exp_p1 = h0[DW-1] ? 1 : 0; exp_g = 0;
            void'(q0.pop_front());
        end else if (want == 1) begin
            exp_data = int'(h1); exp_p0 = h1[DW-1] ? 0 : 1; exp_p1 = h1[DW-1] ? 1 : 0; exp_g = 1;
            void'(q1.pop_front());
        end else begin
            exp_p0 = 0; exp_p1 = 0;
        end

        if (rv || !av) begin
            m_state = 0; streak = 0;
        end else if (m_state == 0) begin
            m_state = 1; streak = 0;
        end else if (want == 0) begin
            s = (m_state == 2) ? 1 : streak + 1;
            if (s == W) begin m_state = 2; streak = 0; end
            else        begin m_state = 1; streak = s; end
        end else if (want == 1 && m_state == 2) begin
            m_state = 1; streak = 0;
        end
    endtask

    int seq[16];
    int dlog[16];
    int exp_seq[11] = '{-1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int n0, n1;

    initial begin
        reset = 1'b1; active = 1'b0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        vc0_data = '0; vc1_data = '0; vc0_empty = 1'b1; vc1_empty = 1'b1;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_d_data", int'(d_data), 0);

        // Weighted share
        for (int i = 0; i < 8; i++) q0.push_back(DW'(i + 1));
        for (int i = 0; i < 4; i++) q1.push_back(DW'(33 + i));
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0);
            seq[i]  = obs_pop;
            dlog[i] = int'(d_data);
        end
        for (int i = 0; i < 11; i++) chk($sformatf("share_order[%0d]", i), seq[i], exp_seq[i]);
        chk("share_first_word", dlog[2], 1);
        chk("share_first_vc1_word", dlog[6], 33);

        // Reset in the middle of a transfer
        for (int i = 0; i < 3; i++) q0.push_back(DW'(3 + i));
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("xfer_d0_push", int'(d0_push), 1);
        step(1, 1, 0, 0);
        chk("rst_d0_push", int'(d0_push), 0);
        chk("rst_d_data", int'(d_data), 0);
        chk("rst_pop", obs_pop, -1);
        step(0, 1, 0, 0);
        chk("post_rst_idle", obs_pop, -1);
        step(0, 1, 0, 0);
        chk("post_rst_first_pop", obs_pop, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

        // Back-pressure on D0
        for (int i = 0; i < 4; i++) begin
            q0.push_back(DW'(1 + i));
            q1.push_back(DW'(33 + i));
        end
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0);
            if (obs_pop == 0) n0++;
            if (obs_pop == 1) n1++;
        end
        chk("bp_vc0_pops", n0, 0);
        chk("bp_vc1_pops", n1, 4);
        step(0, 1, 0, 0);
        chk("bp_resume", obs_pop, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

        // Deactivation
        for (int i = 0; i < 3; i++) begin
            q0.push_back(DW'(10 + i));
            q1.push_back(DW'(40 + i));
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("deact_pop", obs_pop, -1);
        step(0, 0, 0, 0);
        chk("deact_no_push", int'(d0_push | d1_push), 0);
        step(0, 1, 0, 0);
        chk("react_idle", obs_pop, -1);
        step(0, 1, 0, 0);
        chk("react_vc0_first", obs_pop, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

        // Single source on VC1, mixed destinations
        q1.push_back(DW'(1));  q1.push_back(DW'(40)); q1.push_back(DW'(2));
        q1.push_back(DW'(50)); q1.push_back(DW'(3));
        n1 = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            if (obs_pop == 1) n1++;
        end
        chk("single_vc1_pops", n1, 5);
        step(0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(DW'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom_range(0, 63)));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

`ifdef ARB_STALL_CNT_EN
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(DW'(i));
            q1.push_back(DW'(32 + i));
        end
        for (int i = 0; i < 300; i++) step(0, 1, 1, 1);
        chk("stall_saturate", int'(stall_cnt), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
